// File: rtl/zeroheti_mtimer.sv
// -----------------------------------------------------------------------------
// zeroheti_mtimer
//
// RISC-V style machine timer on an OBI slave port. It holds a 64-bit mtime
// counter, a 64-bit mtimecmp compare value and a CTRL register (EN in bit 0,
// PRESC in bits [15:8]). timer_irq_o is a registered (mtime >= mtimecmp).
//
// Register map (word index = (addr_i - BaseAddr) >> 2):
//   0 MTIME_LO  1 MTIME_HI  2 MTIMECMP_LO  3 MTIMECMP_HI  4 CTRL
// Any access outside BaseAddr .. BaseAddr+0x13 responds with err_o=1,
// rdata_o=0 and leaves all state untouched.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_i/gnt_o             OBI request / grant (grant is combinational)
//   addr_i, we_i, be_i,     OBI address phase
//   wdata_i
//   rvalid_o, rdata_o,      OBI response, one cycle after the request
//   err_o
//   timer_irq_o             machine timer interrupt, level
//
// Build option:
//   ZEROHETI_MTIMER_PRESCALER_EN  enables the 8-bit prescaler. Without it,
//   mtime advances every cycle while EN=1 and CTRL[15:8] reads 0.
// -----------------------------------------------------------------------------
module zeroheti_mtimer #(
    parameter logic [31:0] BaseAddr  = 32'h0000_2100,
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic                 timer_irq_o
);

    localparam logic [AddrWidth-1:0] BaseA   = AddrWidth'(BaseAddr);
    localparam logic [AddrWidth-1:0] RegSpan = AddrWidth'(32'h14);

    // Byte-lane merge of a write into an existing 32-bit word.
    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    logic [AddrWidth-1:0] offset;
    logic                 in_range;
    logic [2:0]           word;
    logic                 wr_en;

    assign offset   = addr_i - BaseA;
    // The explicit lower-bound check keeps addresses below BaseAddr from
    // wrapping into the register window.
    assign in_range = (addr_i >= BaseA) && (offset < RegSpan);
    assign word     = offset[4:2];
    assign wr_en    = req_i && we_i && in_range;
    assign gnt_o    = req_i;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        en_q, en_d;
    logic        irq_q, irq_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tick;
    logic [7:0]  presc_rd;

`ifdef ZEROHETI_MTIMER_PRESCALER_EN
    logic [7:0] presc_q, presc_d;
    logic [7:0] cnt_q, cnt_d;

    assign tick     = en_q && (cnt_q == presc_q);
    assign presc_rd = presc_q;

    always_comb begin
        presc_d = presc_q;
        // Count is parked at 0 while disabled so enabling gives a full period.
        if (!en_q || tick) cnt_d = 8'd0;
        else               cnt_d = cnt_q + 8'd1;
        if (wr_en && word == 3'd4 && be_i[1]) begin
            presc_d = wdata_i[15:8];
            cnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign tick     = en_q;
    assign presc_rd = 8'd0;
`endif

    // ---------------------------------------------------------------------
    // Read mux (values as they stand in the request cycle)
    // ---------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = 32'd0;
        if (in_range) begin
            case (word)
                3'd0:    rd_mux = mtime_q[31:0];
                3'd1:    rd_mux = mtime_q[63:32];
                3'd2:    rd_mux = mtimecmp_q[31:0];
                3'd3:    rd_mux = mtimecmp_q[63:32];
                3'd4:    rd_mux = {16'd0, presc_rd, 7'd0, en_q};
                default: rd_mux = 32'd0;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;

        if (tick) mtime_d = mtime_q + 64'd1;

        // A bus write to either mtime word replaces the whole increment:
        // the untouched word keeps its old value, so no carry leaks in.
        if (wr_en) begin
            case (word)
                3'd0: mtime_d = {mtime_q[63:32], merge_be(mtime_q[31:0], wdata_i, be_i)};
                3'd1: mtime_d = {merge_be(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
                3'd2: mtimecmp_d[31:0]  = merge_be(mtimecmp_q[31:0], wdata_i, be_i);
                3'd3: mtimecmp_d[63:32] = merge_be(mtimecmp_q[63:32], wdata_i, be_i);
                3'd4: if (be_i[0]) en_d = wdata_i[0];
                default: ;
            endcase
        end

        irq_d    = (mtime_q >= mtimecmp_q);
        rvalid_d = req_i;
        err_d    = req_i && !in_range;
        rdata_d  = req_i ? rd_mux : 32'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_q       <= 1'b0;
            irq_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            irq_q      <= irq_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_zeroheti_mtimer.sv
// -----------------------------------------------------------------------------
// tb_zeroheti_mtimer
//
// Directed scenarios followed by random OBI traffic. A transaction-level
// model (64-bit arithmetic on mtime/mtimecmp, plus CTRL) predicts every
// response and the interrupt level each cycle. ZEROHETI_MTIMER_PRESCALER_EN
// selects the matching model behaviour.
// -----------------------------------------------------------------------------
module tb_zeroheti_mtimer;

    localparam logic [31:0] BASE = 32'h0000_2100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = 32'd0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    zeroheti_mtimer #(.BaseAddr(BASE), .AddrWidth(32)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .gnt_o      (gnt),
        .addr_i     (addr),
        .we_i       (we),
        .be_i       (be),
        .wdata_i    (wdata),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .err_o      (err),
        .timer_irq_o(irq)
    );

    // ---------------- reference model ----------------
    logic [63:0] m_mtime, m_cmp;
    logic        m_en;
    logic [7:0]  m_presc, m_cnt;
    logic [31:0] last_rd;
    logic        last_err;

    task automatic model_reset();
        m_mtime = 64'd0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en    = 1'b0;
        m_presc = 8'd0;
        m_cnt   = 8'd0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int w);
        case (w)
            0: return m_mtime[31:0];
            1: return m_mtime[63:32];
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
`ifdef ZEROHETI_MTIMER_PRESCALER_EN
            4: return {16'd0, m_presc, 7'd0, m_en};
`else
            4: return {31'd0, m_en};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, predict, clock, compare.
    task automatic step(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        logic        valid, tk;
        int          wi;
        logic [31:0] exp_rd;
        logic        exp_irq;
        logic [63:0] nxt;
        logic [7:0]  cnt_n;
        @(negedge clk);
        req = r; we = w; addr = a; be = b; wdata = d;
        valid   = (a >= BASE) && ((a - BASE) < 32'd20);
        wi      = int'((a - BASE) >> 2);
        exp_rd  = (r && valid) ? m_read(wi) : 32'd0;
        exp_irq = (m_mtime >= m_cmp);
`ifdef ZEROHETI_MTIMER_PRESCALER_EN
        tk = m_en && (m_cnt == m_presc);
`else
        tk = m_en;
`endif
        nxt   = tk ? m_mtime + 64'd1 : m_mtime;
        cnt_n = (!m_en || tk) ? 8'd0 : m_cnt + 8'd1;
        if (r && w && valid) begin
            case (wi)
                0: nxt = {m_mtime[63:32], merge(m_mtime[31:0], d, b)};
                1: nxt = {merge(m_mtime[63:32], d, b), m_mtime[31:0]};
                2: m_cmp[31:0]  = merge(m_cmp[31:0], d, b);
                3: m_cmp[63:32] = merge(m_cmp[63:32], d, b);
                4: begin
                    if (b[0]) m_en = d[0];
`ifdef ZEROHETI_MTIMER_PRESCALER_EN
                    if (b[1]) begin m_presc = d[15:8]; cnt_n = 8'd0; end
`endif
                end
                default: ;
            endcase
        end
        m_mtime = nxt;
        m_cnt   = cnt_n;
        @(posedge clk);
        #1;
        chk("gnt", gnt, r);
        chk("rvalid", rvalid, r);
        chk("rdata", rdata, exp_rd);
        chk("err", err, r && !valid);
        chk("irq", irq, exp_irq);
        last_rd  = rdata;
        last_err = err;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b0, a, 4'hF, $urandom);
    endtask
    task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        step(1'b1, 1'b1, a, b, d);
    endtask
    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_irq", irq, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] ra;
        model_reset();
        last_rd = '0; last_err = 1'b0;
        #3;
        chk("por_rvalid", rvalid, 1'b0);
        chk("por_irq", irq, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Reset values of every register
        rd(BASE + 32'h00); chk("rst_lo", last_rd, 32'h0);
        rd(BASE + 32'h04); chk("rst_hi", last_rd, 32'h0);
        rd(BASE + 32'h08); chk("rst_cmp_lo", last_rd, 32'hFFFF_FFFF);
        rd(BASE + 32'h0C); chk("rst_cmp_hi", last_rd, 32'hFFFF_FFFF);
        rd(BASE + 32'h10); chk("rst_ctrl", last_rd, 32'h0);
        chk("rst_err_flag", last_err, 1'b0);

        // A response in flight when reset asserts is dropped
        rd(BASE);
        do_reset();
        idle();

        // Carry from LO into HI
        wr(BASE + 32'h00, 4'hF, 32'hFFFF_FFFE);
        wr(BASE + 32'h10, 4'hF, 32'h0000_0001);
        idle(); idle();
        rd(BASE + 32'h00); chk("carry_lo", last_rd, 32'h0);
        rd(BASE + 32'h04); chk("carry_hi", last_rd, 32'h1);

        // 64-bit wrap to zero
        wr(BASE + 32'h10, 4'hF, 32'h0);
        wr(BASE + 32'h04, 4'hF, 32'hFFFF_FFFF);
        wr(BASE + 32'h00, 4'hF, 32'hFFFF_FFFF);
        wr(BASE + 32'h10, 4'hF, 32'h1);
        idle();
        rd(BASE + 32'h04); chk("wrap_hi", last_rd, 32'h0);

        // Interrupt rise and fall
        do_reset();
        wr(BASE + 32'h08, 4'hF, 32'd10);
        wr(BASE + 32'h0C, 4'hF, 32'd0);
        wr(BASE + 32'h10, 4'hF, 32'd1);
        chk("irq_low_start", irq, 1'b0);
        repeat (14) idle();
        chk("irq_risen", irq, 1'b1);
        wr(BASE + 32'h0C, 4'hF, 32'd1);
        idle();
        chk("irq_fallen", irq, 1'b0);

        // Out-of-range accesses, including a write that must not land
        rd(BASE + 32'h14); chk("oor_hi_err", last_err, 1'b1); chk("oor_hi_rd", last_rd, 32'h0);
        rd(BASE - 32'h04); chk("oor_lo_err", last_err, 1'b1); chk("oor_lo_rd", last_rd, 32'h0);
        wr(BASE + 32'h14, 4'hF, 32'h1234_5678);
        wr(BASE - 32'h04, 4'hF, 32'h0);
        rd(BASE + 32'h0C); chk("oor_nochange", last_rd, 32'h1);

        // Byte enables and the empty write
        do_reset();
        wr(BASE + 32'h08, 4'b0101, 32'hAABB_CCDD);
        rd(BASE + 32'h08); chk("be_merge", last_rd, 32'hFFBB_FFDD);
        wr(BASE + 32'h08, 4'b0000, 32'h0);
        rd(BASE + 32'h0A); chk("be_zero", last_rd, 32'hFFBB_FFDD);

        // Prescaler
        do_reset();
        wr(BASE + 32'h10, 4'hF, 32'h0000_0301);
        repeat (40) idle();
        rd(BASE + 32'h00);
`ifdef ZEROHETI_MTIMER_PRESCALER_EN
        chk("presc_mtime", last_rd, 32'd10);
        rd(BASE + 32'h10); chk("presc_ctrl", last_rd, 32'h301);
`else
        chk("presc_mtime", last_rd, 32'd40);
        rd(BASE + 32'h10); chk("presc_ctrl", last_rd, 32'h1);
`endif

        // Random traffic
        do_reset();
        wr(BASE + 32'h10, 4'hF, 32'h1);
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                5:       ra = BASE + 32'h14 + ($urandom_range(0, 3) * 4);
                6:       ra = BASE - 32'h04;
                7:       ra = $urandom;
                8, 9:    ra = BASE + ($urandom_range(0, 1) * 4);
                default: ra = BASE + ($urandom_range(0, 4) * 4) + $urandom_range(0, 3);
            endcase
            if ($urandom_range(0, 9) < 8)
                step(1'b1, $urandom_range(0, 1) == 1, ra, 4'($urandom), $urandom);
            else
                idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/zeroheti_mtimer.md
ZEROHETI_MTIMER -- requirements
Module: zeroheti_mtimer

Interface
REQ-001 SHALL have parameter BaseAddr, default 32'h0000_2100, byte address of register 0.
REQ-002 SHALL have parameter AddrWidth, default 32, width of addr_i.
REQ-003 SHALL have port clk_i  input  1  the single clock.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  1  OBI request.
REQ-006 SHALL have port gnt_o  output  1  OBI grant.
REQ-007 SHALL have port addr_i  input  AddrWidth  byte address.
REQ-008 SHALL have port we_i  input  1  write enable.
REQ-009 SHALL have port be_i  input  4  byte enables.
REQ-010 SHALL have port wdata_i  input  32  write data.
REQ-011 SHALL have port rvalid_o  output  1  response valid.
REQ-012 SHALL have port rdata_o  output  32  read data.
REQ-013 SHALL have port err_o  output  1  response error, qualified by rvalid_o.
REQ-014 SHALL have port timer_irq_o  output  1  machine timer interrupt, level.

Function
REQ-015 SHALL drive gnt_o = req_i combinationally; every request is accepted in its request cycle.
REQ-016 SHALL assert rvalid_o for exactly one cycle, the cycle after each granted request; back-to-back requests yield back-to-back responses.
REQ-017 SHALL decode offset = addr_i - BaseAddr, with word index offset[4:2] and offset[1:0] ignored: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL.
REQ-018 SHALL respond err_o=1, rdata_o=0, with no state change for any offset >= 0x14 or addr_i < BaseAddr.
REQ-019 SHALL apply writes per byte lane, updating byte n only where be_i[n]=1; be_i=0 is a legal write with no effect.
REQ-020 SHALL return the register value sampled in the request cycle on rdata_o, held constant while rvalid_o=1, and 0 otherwise.
REQ-021 SHALL define CTRL bit0 as EN and bits[15:8] as PRESC; all other CTRL bits read 0 and ignore writes.
REQ-022 SHALL increment 64-bit mtime by 1 on each tick while EN=1, carrying from LO to HI and wrapping from 2^64-1 to 0.
REQ-023 SHALL, when a bus write to MTIME_LO/HI and a tick fall in the same cycle, let the write win for the written word, with no increment and no carry applied in that cycle.
REQ-024 SHALL drive timer_irq_o as a register set to (mtime >= mtimecmp) from current register values, one cycle of latency after any change.
REQ-025 SHALL deassert timer_irq_o one cycle after a write that makes mtimecmp > mtime.

Reset
REQ-026 SHALL, while rst_ni=0, asynchronously clear mtime to 0, set mtimecmp to 64'hFFFF_FFFF_FFFF_FFFF, clear CTRL and the prescaler count to 0, and drive rvalid_o=0, err_o=0, rdata_o=0, timer_irq_o=0.
REQ-027 SHALL discard any response pending when reset asserts; no rvalid_o follows reset release without a new request.

Configuration
REQ-028 SHALL, with macro ZEROHETI_MTIMER_PRESCALER_EN defined, use an 8-bit prescaler counter: tick when count == PRESC, then count restarts at 0; PRESC=0 ticks every cycle; a PRESC write restarts the count at 0; EN=0 holds the count at 0.
REQ-029 SHALL, without ZEROHETI_MTIMER_PRESCALER_EN, tick every cycle while EN=1, read CTRL[15:8] as 0 and ignore writes to it.

Verification
REQ-030 SHALL cover: reset, then read 0x2100..0x2110 -> 0, 0, FFFF_FFFF, FFFF_FFFF, 0, err_o=0, timer_irq_o=0.
REQ-031 SHALL cover: write MTIME_LO=FFFF_FFFE, EN=1, PRESC=0, wait 2 cycles -> MTIME_HI=1, MTIME_LO=0.
REQ-032 SHALL cover: mtimecmp=10, EN=1 from mtime=0 -> timer_irq_o rises once mtime >= 10; write MTIMECMP_HI=1 -> irq falls one cycle later.
REQ-033 SHALL cover: read 0x2114 and 0x20FC -> rvalid_o one cycle later with err_o=1, rdata_o=0, registers unchanged.
REQ-034 SHALL cover: write MTIMECMP_LO=AABBCCDD with be_i=4'b0101 after reset -> reads FFBBFFDD.
REQ-035 SHALL cover, with ZEROHETI_MTIMER_PRESCALER_EN: PRESC=3, EN=1 for 40 cycles -> mtime=10; without the macro, same stimulus -> mtime=40, CTRL reads 1.
